// File: rtl/snn_pkg.sv
// Shared packet field offsets, type codes and FSM state encoding for the
// single-PE spiking convolution node.
package snn_pkg;

  localparam int unsigned TS_BIT    = 5;
  localparam int unsigned TYPE_LSB  = 6;
  localparam int unsigned SPIKE_BIT = 9;
  localparam int unsigned PE_LSB    = 10;
  localparam int unsigned RES_LSB   = 21;
  localparam int unsigned DATA_LSB  = 9;

  localparam logic [2:0] TYPE_IFMAP = 3'b000;
  localparam logic [2:0] TYPE_ROW1  = 3'b011;
  localparam logic [2:0] TYPE_ROW2  = 3'b101;
  localparam logic [2:0] TYPE_ROW3  = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    FIRE = 3'd4,
    SEND = 3'd5
  } state_t;

endpackage

// File: rtl/row_mac.sv
// Combinational partial sum of one filter row: each weight is added when its
// binary ifmap bit is set. Bit j of i_bits pairs with weight slice j.
module row_mac #(
  parameter int unsigned W  = 8,
  parameter int unsigned OW = 12
) (
  input  logic [3*W-1:0] i_w,
  input  logic [2:0]     i_bits,
  output logic [OW-1:0]  o_sum
);

  // Gated sum of the three weights of the selected row
  always_comb begin
    o_sum = '0;
    for (int j = 0; j < 3; j++) begin
      if (i_bits[j]) begin
        o_sum = o_sum + OW'(i_w[j*W +: W]);
      end else begin
        o_sum = o_sum;
      end
    end
  end

endmodule

// File: rtl/top.sv
// Single-PE spiking convolution node: filter rows and binary ifmaps arrive as
// packets; each ifmap is integrated into a membrane potential that may fire.
module top
  import snn_pkg::*;
#(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned IFMAP_SIZE   = 9,
  parameter int unsigned OUTPUT_WIDTH = 12,
  parameter int unsigned THRESHOLD    = 64,
  parameter logic [1:0]  PE_ID        = 2'd0,
  parameter int unsigned PKT_WIDTH    = 3*FILTER_WIDTH+9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PKT_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PKT_WIDTH-1:0] out_data
);

  localparam int unsigned ROW_W = 3*FILTER_WIDTH;
  localparam logic [OUTPUT_WIDTH-1:0] THR   = OUTPUT_WIDTH'(THRESHOLD);
  localparam logic [OUTPUT_WIDTH-1:0] SAT_V = {OUTPUT_WIDTH{1'b1}};

  state_t                  r_state;
  logic [ROW_W-1:0]        r_row [3];
  logic [2:0]              r_loaded;
  logic [IFMAP_SIZE-1:0]   r_ifmap;
  logic                    r_ts;
  logic [OUTPUT_WIDTH-1:0] r_acc;
  logic [OUTPUT_WIDTH-1:0] r_pot;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [PKT_WIDTH-1:0]    r_out_data;

  logic                    w_accept;
  logic [2:0]              w_type;
  logic [ROW_W-1:0]        w_payload;
  logic [ROW_W-1:0]        w_sel_w;
  logic [2:0]              w_sel_b;
  logic [OUTPUT_WIDTH-1:0] w_psum;
  logic [OUTPUT_WIDTH:0]   w_sum_wide;
  logic [OUTPUT_WIDTH-1:0] w_sum;
  logic                    w_spike;
  logic [OUTPUT_WIDTH-1:0] w_new_pot;
  logic [PKT_WIDTH-1:0]    w_out_pkt;
  logic                    w_unused_bits;

  assign w_accept      = in_valid && r_in_ready;
  assign w_type        = in_data[TYPE_LSB +: 3];
  assign w_payload     = in_data[PKT_WIDTH-1 -: ROW_W];
  // Routing bits are carried for the fabric but have no meaning at this node
  assign w_unused_bits = ^in_data[4:0];

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Select the filter row and matching ifmap bits for the current MAC cycle
  always_comb begin
    w_sel_w = '0;
    w_sel_b = 3'b000;
    case (r_state)
      MAC0: begin
        w_sel_w = r_row[0];
        w_sel_b = r_ifmap[2:0];
      end
      MAC1: begin
        w_sel_w = r_row[1];
        w_sel_b = r_ifmap[5:3];
      end
      MAC2: begin
        w_sel_w = r_row[2];
        w_sel_b = r_ifmap[8:6];
      end
      default: begin
        w_sel_w = '0;
        w_sel_b = 3'b000;
      end
    endcase
  end

  row_mac #(
    .W  (FILTER_WIDTH),
    .OW (OUTPUT_WIDTH)
  ) u_row_mac (
    .i_w    (w_sel_w),
    .i_bits (w_sel_b),
    .o_sum  (w_psum)
  );

  // Saturating integrate and threshold compare, plus output packet assembly
  always_comb begin
    w_sum_wide = {1'b0, r_pot} + {1'b0, r_acc};
    if (w_sum_wide[OUTPUT_WIDTH]) begin
      w_sum = SAT_V;
    end else begin
      w_sum = w_sum_wide[OUTPUT_WIDTH-1:0];
    end
    if (w_sum >= THR) begin
      w_spike   = 1'b1;
      w_new_pot = w_sum - THR;
    end else begin
      w_spike   = 1'b0;
      w_new_pot = w_sum;
    end
    w_out_pkt                            = '0;
    w_out_pkt[TS_BIT]                    = r_ts;
    w_out_pkt[SPIKE_BIT]                 = w_spike;
    w_out_pkt[PE_LSB +: 2]               = PE_ID;
    w_out_pkt[RES_LSB +: OUTPUT_WIDTH]   = w_new_pot;
  end

  // Main control FSM with all state and outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      for (int r = 0; r < 3; r++) begin
        r_row[r] <= '0;
      end
      r_loaded    <= 3'b000;
      r_ifmap     <= '0;
      r_ts        <= 1'b0;
      r_acc       <= '0;
      r_pot       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            case (w_type)
              TYPE_ROW1: begin
                r_row[0]    <= w_payload;
                r_loaded[0] <= 1'b1;
              end
              TYPE_ROW2: begin
                r_row[1]    <= w_payload;
                r_loaded[1] <= 1'b1;
              end
              TYPE_ROW3: begin
                r_row[2]    <= w_payload;
                r_loaded[2] <= 1'b1;
              end
              TYPE_IFMAP: begin
                // An ifmap against an incomplete filter is consumed and dropped
                if (&r_loaded) begin
                  r_ifmap    <= in_data[DATA_LSB +: IFMAP_SIZE];
                  r_ts       <= in_data[TS_BIT];
                  r_acc      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= MAC0;
                end
              end
              default: r_state <= IDLE;
            endcase
          end
        end
        MAC0: begin
          r_acc   <= r_acc + w_psum;
          r_state <= MAC1;
        end
        MAC1: begin
          r_acc   <= r_acc + w_psum;
          r_state <= MAC2;
        end
        MAC2: begin
          r_acc   <= r_acc + w_psum;
          r_state <= FIRE;
        end
        FIRE: begin
          r_pot       <= w_new_pot;
          r_out_data  <= w_out_pkt;
          r_out_valid <= 1'b1;
          r_state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// Bench for the spiking convolution node: directed sequence plus randomized
// packets checked against a behavioural integrate-and-fire model.
module tb_top;

  localparam logic [1:0] PE = 2'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int w [9];
  bit loaded [3];
  int pot;

  top dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 9; k++) w[k] = 0;
    for (int r = 0; r < 3; r++) loaded[r] = 1'b0;
    pot = 0;
  endfunction

  // Returns 1 when the packet should produce an output, with its expected value
  function automatic bit model_pkt(input logic [32:0] d, output logic [32:0] exp);
    int t, r, acc, sum, spk;
    logic [32:0] res, ts;
    exp = '0;
    t = int'(d[8:6]);
    if (t == 3 || t == 5 || t == 7) begin
      r = (t - 3) / 2;
      w[3*r]   = int'(d[32:25]);
      w[3*r+1] = int'(d[24:17]);
      w[3*r+2] = int'(d[16:9]);
      loaded[r] = 1'b1;
      return 1'b0;
    end
    if (t != 0 || !(loaded[0] && loaded[1] && loaded[2])) return 1'b0;
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      if (d[9 + 3*(k/3) + 2 - (k%3)]) acc += w[k];
    end
    sum = pot + acc;
    if (sum > 4095) sum = 4095;
    spk = (sum >= 64) ? 1 : 0;
    pot = spk ? sum - 64 : sum;
    res = 33'(pot);
    ts  = 33'(d[5]);
    exp = (res << 21) | (33'(PE) << 10) | (33'(spk) << 9) | (ts << 5);
    return 1'b1;
  endfunction

  function automatic logic [32:0] row_pkt(input int r, input int a, input int b, input int c);
    logic [32:0] p;
    logic [2:0] code;
    p = 33'($urandom) & 33'h1F;
    code = 3'(2*r + 1);
    p[8:6]   = code;
    p[32:25] = 8'(a);
    p[24:17] = 8'(b);
    p[16:9]  = 8'(c);
    return p;
  endfunction

  // i[k] is ifmap element k; unused payload and routing bits are randomized
  function automatic logic [32:0] ifmap_pkt(input logic [8:0] i, input logic ts);
    logic [32:0] p;
    p = {$urandom, 1'b0};
    p[8:6] = 3'b000;
    p[5]   = ts;
    for (int k = 0; k < 9; k++) p[9 + 3*(k/3) + 2 - (k%3)] = i[k];
    return p;
  endfunction

  task automatic drive(input logic [32:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom, 1'b1};
  endtask

  task automatic expect_out(input logic [32:0] exp, input int hold, output logic [32:0] got);
    int cnt;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("out_latency", 64'(cnt), 64'd4);
    check_eq("out_data", 64'(out_data), 64'(exp));
    check_eq("in_ready_in_send", 64'(in_ready), 64'd0);
    got = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_eq("hold_data", 64'(out_data), 64'(exp));
      check_eq("hold_valid_ready", 64'({out_valid, in_ready}), 64'b10);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("after_xfer_valid", 64'(out_valid), 64'd0);
    check_eq("after_xfer_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic expect_none();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    check_eq("no_output", 64'(seen), 64'd0);
    check_eq("idle_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic apply(input logic [32:0] d, input int hold, output logic [32:0] got);
    logic [32:0] exp;
    bit has;
    has = model_pkt(d, exp);
    drive(d);
    got = '0;
    if (has) expect_out(exp, hold, got);
    else expect_none();
  endtask

  logic [8:0] t1 = 9'b111000111;
  logic [8:0] t2 = 9'b000111100;

  initial begin
    logic [32:0] got;
    logic [32:0] junk;
    int kind;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ifmap before the filter is complete is accepted and dropped
    apply(row_pkt(1, 5, 5, 5), 0, got);
    apply(row_pkt(2, 5, 4, 3), 0, got);
    apply(ifmap_pkt(t1, 1'b0), 0, got);
    apply(row_pkt(3, 0, 2, 5), 0, got);

    apply(ifmap_pkt(t1, 1'b0), 0, got);
    check_eq("t1_res", 64'(got[32:21]), 64'd22);
    check_eq("t1_spike_ts_pe", 64'({got[9], got[5], got[11:10]}), 64'({1'b0, 1'b0, PE}));
    apply(ifmap_pkt(t2, 1'b1), 10, got);
    check_eq("t2_res", 64'(got[32:21]), 64'd39);
    check_eq("t2_spike_ts", 64'({got[9], got[5]}), 64'b01);
    apply(ifmap_pkt(t1, 1'b0), 0, got);
    check_eq("t3_res", 64'(got[32:21]), 64'd61);
    junk = row_pkt(1, 9, 9, 9);
    junk[8:6] = 3'b001;
    apply(junk, 0, got);
    apply(ifmap_pkt(t2, 1'b1), 1, got);
    check_eq("t4_res", 64'(got[32:21]), 64'd14);
    check_eq("t4_spike", 64'(got[9]), 64'd1);

    // Reset in MAC1 aborts the packet and forgets the filter and potential
    drive(ifmap_pkt(t1, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_out_data", 64'(out_data), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(ifmap_pkt(t1, 1'b0), 0, got);
    apply(row_pkt(1, 5, 5, 5), 0, got);
    apply(row_pkt(2, 5, 4, 3), 0, got);
    apply(row_pkt(3, 0, 2, 5), 0, got);
    apply(ifmap_pkt(t1, 1'b0), 0, got);
    check_eq("postrst_res", 64'(got[32:21]), 64'd22);

    // Randomized traffic against the model
    for (int it = 0; it < 120; it++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 2) begin
        apply(row_pkt(kind + 1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255))), 0, got);
      end else if (kind <= 7) begin
        apply(ifmap_pkt(9'($urandom), 1'($urandom)), int'($urandom_range(0, 3)), got);
      end else begin
        junk = {$urandom, 1'b0};
        case ($urandom_range(0, 3))
          0: junk[8:6] = 3'b001;
          1: junk[8:6] = 3'b010;
          2: junk[8:6] = 3'b100;
          default: junk[8:6] = 3'b110;
        endcase
        apply(junk, 0, got);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- Single-PE spiking convolution node with a packet interface. Sits at the edge of the SNN fabric.
- Accepts 33-bit packets that load the three rows of a 3x3 filter, or deliver one 3x3 binary ifmap per timestep.
- For each ifmap it computes the dot product with the filter and integrates it into a membrane potential (integrate-and-fire).
- Emits one output packet carrying the spike bit and the residual potential.

Parameters:
- FILTER_WIDTH, 8, unsigned filter weight width.
- IFMAP_SIZE, 9, ifmap elements per packet (3x3).
- OUTPUT_WIDTH, 12, membrane-potential / residue width.
- THRESHOLD, 64, firing threshold.
- PE_ID, 2'd0, node id written into output packet bits [11:10].
- PKT_WIDTH, 3*FILTER_WIDTH+9 (=33), packet width.

Ports:
- clk, input, 1, the single clock.
- rst_n, input, 1, reset, asynchronous active-low.
- in_valid, input, 1, packet present.
- in_ready, output, 1, packet accepted when in_valid&&in_ready at a rising edge.
- in_data, input, PKT_WIDTH, input packet.
- out_valid, output, 1, output packet valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, PKT_WIDTH, output packet.

Behaviour:
- Packet fields:
  - [1:0] direction, [3:2] x-hop, [4] y-hop: all ignored on input.
  - [5] timestep.
  - [8:6] type: 011 = filter row 1, 101 = row 2, 111 = row 3, 000 = ifmap. Any other code is accepted and dropped.
- Filter payload: w0 at [32:25], w1 at [24:17], w2 at [16:9]. Row r supplies filter elements 3(r-1)..3(r-1)+2.
- Ifmap payload, bits [17:9]:
  - Row 1: i2@9, i1@10, i0@11.
  - Row 2: i5@12, i4@13, i3@14.
  - Row 3: i8@15, i7@16, i6@17.
  - Bits [32:18] are ignored.
- Reset (async, rst_n=0):
  - State IDLE, in_ready=0 during reset, out_valid=0, out_data=0.
  - Filter registers and row-loaded flags cleared; potential=0.
  - Reset mid-operation discards any packet in flight.
- FSM states: IDLE, MAC0, MAC1, MAC2, FIRE, SEND.
- IDLE:
  - in_ready=1.
  - A filter packet overwrites its row and sets its loaded flag, then stays in IDLE with no output.
  - An ifmap packet with all three rows loaded latches ifmap and timestep, clears the accumulator and moves to MAC0.
  - An ifmap packet with any row unloaded is accepted and dropped.
- MAC0..MAC2:
  - in_ready=0.
  - Each cycle adds the sum over k in row of w_k*i_k (a weight is added when its ifmap bit is 1).
  - Then advance; MAC2 goes to FIRE.
- FIRE:
  - sum = potential + acc, saturating at 2^OUTPUT_WIDTH-1.
  - If sum >= THRESHOLD: spike=1 and potential = sum - THRESHOLD. Otherwise spike=0 and potential = sum.
  - Register out_data, assert out_valid, go to SEND.
  - out_valid rises at the 4th rising edge after the accepting edge.
- Output packet:
  - [1:0]=00, [4:2]=000, [5]=latched timestep, [8:6]=000.
  - [9]=spike, [11:10]=PE_ID, [20:12]=0, [32:21]=new potential (residue).
- SEND:
  - out_valid and out_data are held stable until out_ready=1 at an edge, then return to IDLE.
  - in_ready=0 throughout SEND; there is no input/output overlap.
- Potential persists across timesteps. Reloading filter rows does not clear it.
- All arithmetic is unsigned. Accumulator is OUTPUT_WIDTH bits; the maximum 9*255 fits 12 bits.

Decomposition:
- Shared package snn_pkg holds:
  - Field offsets (TS_BIT=5, TYPE_LSB=6, SPIKE_BIT=9, PE_LSB=10, RES_LSB=21).
  - Type codes (TYPE_IFMAP=3'b000, TYPE_ROW1=3'b011, TYPE_ROW2=3'b101, TYPE_ROW3=3'b111).
  - typedef enum state_t.
- One sub-module, row_mac: combinational 3 weights x 3 bits -> partial sum. The top instantiates it once and muxes the row per MAC state.

Test Plan:
- Load rows {5,5,5},{5,4,3},{0,2,5}, then send ifmap t1 (i=1,1,1,0,0,0,1,1,1; ts=0) -> one output: spike=0, residue=22, [5]=0, [11:10]=PE_ID; out_valid at 4th edge after accept.
- Then ifmap t2 (i=0,0,1,1,1,1,0,0,0; ts=1) -> spike=0, residue=39. Then t1 -> residue=61. Then t2 -> spike=1, residue=14 (78-64).
- Ifmap sent before all three rows are loaded -> accepted (in_ready=1), no output, potential unchanged; a later valid sequence gives 22 as above.
- Hold out_ready=0 for 10 cycles during SEND -> out_data stable, in_ready=0; on release, one transfer then return to IDLE.
- Packet with type 3'b001 -> dropped, no output. Assert rst_n=0 during MAC1 -> out_valid=0, potential=0, flags cleared; the next ifmap without filter reload is dropped.
